// File: rtl/rs_unified_pkg.sv
// rs_unified_pkg: shared pipeline packet types and the reservation-station entry layout.
package rs_unified_pkg;
    localparam int RS_ENTRIES_DEFAULT = 16;
    localparam int PREG_IDX_WIDTH     = 6;
    localparam int ROB_IDX_WIDTH      = 7;
    localparam int LSQ_IDX_WIDTH      = 4;

    typedef enum logic [2:0] {FU_ALU, FU_LOAD, FU_STORE, FU_MULT, FU_BR} fu_e;

    typedef struct packed {
        logic                      valid;
        logic [31:0]               inst;
        logic [31:0]               pc;
        fu_e                       fu;
        logic [PREG_IDX_WIDTH-1:0] dest_preg;
        logic [PREG_IDX_WIDTH-1:0] prega_idx;
        logic                      prega_ready;
        logic [PREG_IDX_WIDTH-1:0] pregb_idx;
        logic                      pregb_ready;
    } RN_DP_PACKET;

    typedef struct packed {
        logic                      cdb_valid;
        logic [PREG_IDX_WIDTH-1:0] cdb_tag;
    } CDB_PACKET;

    typedef struct packed {
        logic                      valid;
        logic [31:0]               inst;
        logic [31:0]               pc;
        fu_e                       fu;
        logic [PREG_IDX_WIDTH-1:0] dest_preg;
        logic [PREG_IDX_WIDTH-1:0] prega_idx;
        logic [PREG_IDX_WIDTH-1:0] pregb_idx;
        logic [ROB_IDX_WIDTH-1:0]  rob_idx;
        logic [LSQ_IDX_WIDTH-1:0]  sq_idx;
        logic [LSQ_IDX_WIDTH-1:0]  lq_idx;
        logic                      ALU_ready;
        logic                      LOAD_ready;
        logic                      STORE_ready;
        logic                      MULT_ready;
        logic                      BR_ready;
    } IS_EX_PACKET;

    typedef struct packed {
        logic [31:0]               inst;
        logic [31:0]               pc;
        fu_e                       fu;
        logic [PREG_IDX_WIDTH-1:0] dest_preg;
        logic [PREG_IDX_WIDTH-1:0] prega_idx;
        logic [PREG_IDX_WIDTH-1:0] pregb_idx;
        logic [ROB_IDX_WIDTH-1:0]  rob_idx;
        logic [LSQ_IDX_WIDTH-1:0]  sq_idx;
        logic [LSQ_IDX_WIDTH-1:0]  lq_idx;
        logic                      prega_ready;
        logic                      pregb_ready;
        logic                      valid;
    } RS_ENTRY;

    function automatic IS_EX_PACKET to_issue(input RS_ENTRY e);
        IS_EX_PACKET p;
        p.valid       = e.valid && e.prega_ready && e.pregb_ready;
        p.inst        = e.inst;
        p.pc          = e.pc;
        p.fu          = e.fu;
        p.dest_preg   = e.dest_preg;
        p.prega_idx   = e.prega_idx;
        p.pregb_idx   = e.pregb_idx;
        p.rob_idx     = e.rob_idx;
        p.sq_idx      = e.sq_idx;
        p.lq_idx      = e.lq_idx;
        p.ALU_ready   = e.fu == FU_ALU;
        p.LOAD_ready  = e.fu == FU_LOAD;
        p.STORE_ready = e.fu == FU_STORE;
        p.MULT_ready  = e.fu == FU_MULT;
        p.BR_ready    = e.fu == FU_BR;
        return p;
    endfunction
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: age matrix plus oldest-first grant per issue port.
// A port stalled by execute keeps its entry pinned until it is accepted.
module rs_age_select
    import rs_unified_pkg::*;
#(
    parameter int ENTRIES = RS_ENTRIES_DEFAULT,
    parameter int WAYS    = 2,
    parameter int ISSUE   = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic [ENTRIES-1:0] alloc_i [WAYS],
    input  logic [ENTRIES-1:0] eligible_i,
    input  logic [ISSUE-1:0]   stall_i,
    output logic [ENTRIES-1:0] grant_o [ISSUE]
);
    localparam int CW = $clog2(ENTRIES + 1);
    localparam int LW = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [ENTRIES-1:0] age_q [ENTRIES];
    logic [ENTRIES-1:0] age_d [ENTRIES];
    logic [ENTRIES-1:0] hold_q [ISSUE];
    logic [ENTRIES-1:0] hold_d [ISSUE];
    logic [ENTRIES-1:0] written, pool, held;
    logic [LW-1:0]      lane [ENTRIES];
    logic [CW-1:0]      rank [ENTRIES];
    logic [CW-1:0]      slot_cnt;
    logic [ISSUE-1:0]   hold_v;

    // New entries are younger than everything; inside a bundle lower lanes are older
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            written[i] = 1'b0;
            lane[i]    = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (alloc_i[w][i]) begin
                    written[i] = 1'b1;
                    lane[i]    = LW'(w);
                end
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                age_d[i][j] = (written[i] && written[j]) ? (lane[i] < lane[j]) :
                              written[j] ? 1'b1 : written[i] ? 1'b0 : age_q[i][j];
            end
        end
    end

    always_comb begin
        held = '0;
        for (int k = 0; k < ISSUE; k++) begin
            hold_v[k] = |hold_q[k];
            held     |= hold_q[k];
        end
        pool = eligible_i & ~held;
        for (int i = 0; i < ENTRIES; i++) begin
            rank[i] = '0;
            for (int j = 0; j < ENTRIES; j++) rank[i] += CW'(pool[j] && age_q[j][i]);
        end
        // Free ports take the remaining pool in age order, skipping pinned ports
        for (int k = 0; k < ISSUE; k++) begin
            slot_cnt = '0;
            for (int m = 0; m < k; m++) slot_cnt += CW'(!hold_v[m]);
            for (int i = 0; i < ENTRIES; i++) begin
                grant_o[k][i] = hold_v[k] ? hold_q[k][i] : (pool[i] && rank[i] == slot_cnt);
            end
            hold_d[k] = (flush_i || !stall_i[k]) ? '0 : grant_o[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q  <= '{default: '0};
            hold_q <= '{default: '0};
        end else begin
            age_q  <= age_d;
            hold_q <= hold_d;
        end
    end
endmodule

// File: rtl/rs_unified.sv
// rs_unified: shared reservation station with CDB wakeup, dispatch bypass and
// oldest-first multi-port issue.
module rs_unified
    import rs_unified_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int ISSUE   = 2,
    parameter int ENTRIES = RS_ENTRIES_DEFAULT,
    parameter int CDB_W   = 2
) (
    input  logic                          clock_i,
    input  logic                          reset_ni,
    input  logic                          flush_i,
    input  logic                          dp_stall_i,
    input  RN_DP_PACKET                   rn_dp_packet_i [WAYS],
    input  logic [ROB_IDX_WIDTH-1:0]      rob_idx_i [WAYS],
    input  logic [LSQ_IDX_WIDTH-1:0]      sq_idx_i [WAYS],
    input  logic [LSQ_IDX_WIDTH-1:0]      lq_idx_i [WAYS],
    input  CDB_PACKET                     cdb_packet_i [CDB_W],
    input  logic [ISSUE-1:0]              is_stall_i,
    output IS_EX_PACKET                   rs_packet_o [ISSUE],
    output logic [$clog2(ENTRIES+1)-1:0]  rs_free_cnt_o,
    output logic                          rs_full_o
);
    localparam int CW = $clog2(ENTRIES + 1);

    RS_ENTRY            entries_q [ENTRIES];
    RS_ENTRY            entries_d [ENTRIES];
    RS_ENTRY            new_entry [WAYS];
    logic [CW-1:0]      free_cnt_q, free_cnt_d;
    logic [ENTRIES-1:0] occ, eligible, freed, avail;
    logic [ENTRIES-1:0] alloc [WAYS];
    logic [ENTRIES-1:0] grant [ISSUE];
    logic               accept;

    assign rs_free_cnt_o = free_cnt_q;
    assign rs_full_o     = free_cnt_q < CW'(WAYS);
    assign accept        = !dp_stall_i && !rs_full_o && !flush_i;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            occ[i]      = entries_q[i].valid;
            eligible[i] = entries_q[i].valid && entries_q[i].prega_ready && entries_q[i].pregb_ready;
        end
        avail = ~occ;
        for (int w = 0; w < WAYS; w++) begin
            alloc[w] = (accept && rn_dp_packet_i[w].valid) ? (avail & (-avail)) : '0;
            avail   &= ~alloc[w];
        end
        freed = '0;
        for (int k = 0; k < ISSUE; k++) freed |= is_stall_i[k] ? '0 : grant[k];
    end

    // Same-cycle CDB tags count as ready for a freshly written entry
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            new_entry[w].inst        = rn_dp_packet_i[w].inst;
            new_entry[w].pc          = rn_dp_packet_i[w].pc;
            new_entry[w].fu          = rn_dp_packet_i[w].fu;
            new_entry[w].dest_preg   = rn_dp_packet_i[w].dest_preg;
            new_entry[w].prega_idx   = rn_dp_packet_i[w].prega_idx;
            new_entry[w].pregb_idx   = rn_dp_packet_i[w].pregb_idx;
            new_entry[w].rob_idx     = rob_idx_i[w];
            new_entry[w].sq_idx      = sq_idx_i[w];
            new_entry[w].lq_idx      = lq_idx_i[w];
            new_entry[w].prega_ready = rn_dp_packet_i[w].prega_ready;
            new_entry[w].pregb_ready = rn_dp_packet_i[w].pregb_ready;
            new_entry[w].valid       = 1'b1;
            for (int c = 0; c < CDB_W; c++) begin
                new_entry[w].prega_ready |= cdb_packet_i[c].cdb_valid &&
                                            cdb_packet_i[c].cdb_tag == rn_dp_packet_i[w].prega_idx;
                new_entry[w].pregb_ready |= cdb_packet_i[c].cdb_valid &&
                                            cdb_packet_i[c].cdb_tag == rn_dp_packet_i[w].pregb_idx;
            end
        end
    end

    always_comb begin
        free_cnt_d = CW'(ENTRIES);
        for (int i = 0; i < ENTRIES; i++) begin
            entries_d[i] = entries_q[i];
            for (int c = 0; c < CDB_W; c++) begin
                entries_d[i].prega_ready |= cdb_packet_i[c].cdb_valid &&
                                            cdb_packet_i[c].cdb_tag == entries_q[i].prega_idx;
                entries_d[i].pregb_ready |= cdb_packet_i[c].cdb_valid &&
                                            cdb_packet_i[c].cdb_tag == entries_q[i].pregb_idx;
            end
            if (freed[i]) entries_d[i].valid = 1'b0;
            for (int w = 0; w < WAYS; w++) if (alloc[w][i]) entries_d[i] = new_entry[w];
            if (flush_i) entries_d[i].valid = 1'b0;
            free_cnt_d -= CW'(entries_d[i].valid);
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE; k++) begin
            rs_packet_o[k] = '0;
            for (int i = 0; i < ENTRIES; i++) if (grant[k][i]) rs_packet_o[k] = to_issue(entries_q[i]);
        end
    end

    rs_age_select #(.ENTRIES(ENTRIES), .WAYS(WAYS), .ISSUE(ISSUE)) u_age_select (
        .clk_i      (clock_i),
        .rst_ni     (reset_ni),
        .flush_i    (flush_i),
        .alloc_i    (alloc),
        .eligible_i (eligible),
        .stall_i    (is_stall_i),
        .grant_o    (grant)
    );

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            entries_q  <= '{default: '0};
            free_cnt_q <= CW'(ENTRIES);
        end else begin
            entries_q  <= entries_d;
            free_cnt_q <= free_cnt_d;
        end
    end
endmodule

// File: tb/tb_rs_unified.sv
// tb_rs_unified: directed vector table plus hand sequences for fill, age, stall, flush and reset.
module tb_rs_unified;
    import rs_unified_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset_n;
    logic                     flush, dp_stall;
    RN_DP_PACKET              rn [2];
    logic [ROB_IDX_WIDTH-1:0] rob [2];
    logic [LSQ_IDX_WIDTH-1:0] sq [2];
    logic [LSQ_IDX_WIDTH-1:0] lq [2];
    CDB_PACKET                cdb [2];
    logic [1:0]               is_stall;
    IS_EX_PACKET              pkt [2];
    logic [4:0]               free_cnt;
    logic                     full;
    int                       total = 0;
    int                       passed = 0;

    typedef struct {
        int l0v, l0r, l0t, l0k, l1v, l1r, cv, cch, ctag, dps;
        int e0v, e0r, e1v, e1r, ecnt, efull;
    } vec_t;
    vec_t vecs [17];

    rs_unified #(.WAYS(2), .ISSUE(2), .ENTRIES(16), .CDB_W(2)) dut (
        .clock_i        (clock),
        .reset_ni       (reset_n),
        .flush_i        (flush),
        .dp_stall_i     (dp_stall),
        .rn_dp_packet_i (rn),
        .rob_idx_i      (rob),
        .sq_idx_i       (sq),
        .lq_idx_i       (lq),
        .cdb_packet_i   (cdb),
        .is_stall_i     (is_stall),
        .rs_packet_o    (pkt),
        .rs_free_cnt_o  (free_cnt),
        .rs_full_o      (full)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    task automatic ports(input string nm, input int v0, input int r0, input int v1, input int r1);
        check({nm, " p0.valid"}, int'(pkt[0].valid), v0);
        if (v0 != 0) check({nm, " p0.rob"}, int'(pkt[0].rob_idx), r0);
        check({nm, " p1.valid"}, int'(pkt[1].valid), v1);
        if (v1 != 0) check({nm, " p1.rob"}, int'(pkt[1].rob_idx), r1);
    endtask

    task automatic idle();
        for (int w = 0; w < 2; w++) begin
            rn[w]  = '0;
            rob[w] = '0;
            sq[w]  = '0;
            lq[w]  = '0;
            cdb[w] = '0;
        end
        is_stall = '0;
        flush    = 1'b0;
        dp_stall = 1'b0;
    endtask

    task automatic lane(input int w, input int r, input int tag, input int rdy);
        rn[w]             = '0;
        rn[w].valid       = 1'b1;
        rn[w].fu          = FU_ALU;
        rn[w].inst        = 32'(r);
        rn[w].prega_idx   = PREG_IDX_WIDTH'(tag);
        rn[w].prega_ready = rdy != 0;
        rn[w].pregb_ready = 1'b1;
        rob[w]            = ROB_IDX_WIDTH'(r);
    endtask

    task automatic bcast(input int ch, input int tag);
        cdb[ch].cdb_valid = 1'b1;
        cdb[ch].cdb_tag   = PREG_IDX_WIDTH'(tag);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          l0v l0r l0t l0k l1v l1r cv cch ctag dps e0v e0r e1v e1r cnt full
        vecs[0]  = '{1, 3,  0,  1,  1, 4,  0, 0, 0,  0,  0, 0,  0, 0,  16, 0};
        vecs[1]  = '{0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  1, 3,  1, 4,  14, 0};
        vecs[2]  = '{1, 5,  12, 0,  0, 0,  0, 0, 0,  0,  0, 0,  0, 0,  16, 0};
        vecs[3]  = '{0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  0, 0,  0, 0,  15, 0};
        vecs[4]  = '{0, 0,  0,  0,  0, 0,  1, 0, 12, 0,  0, 0,  0, 0,  15, 0};
        vecs[5]  = '{0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  1, 5,  0, 0,  15, 0};
        vecs[6]  = '{1, 6,  12, 0,  0, 0,  1, 1, 12, 0,  0, 0,  0, 0,  16, 0};
        vecs[7]  = '{0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  1, 6,  0, 0,  15, 0};
        vecs[8]  = '{1, 7,  0,  1,  0, 0,  0, 0, 0,  1,  0, 0,  0, 0,  16, 0};
        vecs[9]  = '{1, 8,  20, 0,  0, 0,  1, 0, 21, 0,  0, 0,  0, 0,  16, 0};
        vecs[10] = '{0, 0,  0,  0,  0, 0,  1, 1, 21, 0,  0, 0,  0, 0,  15, 0};
        vecs[11] = '{0, 0,  0,  0,  0, 0,  1, 1, 20, 0,  0, 0,  0, 0,  15, 0};
        vecs[12] = '{0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  1, 8,  0, 0,  15, 0};
        vecs[13] = '{0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  0, 0,  0, 0,  16, 0};
        vecs[14] = '{0, 0,  0,  0,  1, 11, 0, 0, 0,  0,  0, 0,  0, 0,  16, 0};
        vecs[15] = '{0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  1, 11, 0, 0,  15, 0};
        vecs[16] = '{0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  0, 0,  0, 0,  16, 0};

        reset_n = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        ports("reset", 0, 0, 0, 0);
        check("reset free_cnt", int'(free_cnt), 16);
        check("reset full", int'(full), 0);

        for (int v = 0; v < 17; v++) begin
            if (vecs[v].l0v != 0) lane(0, vecs[v].l0r, vecs[v].l0t, vecs[v].l0k);
            if (vecs[v].l1v != 0) lane(1, vecs[v].l1r, 0, 1);
            if (vecs[v].cv != 0) bcast(vecs[v].cch, vecs[v].ctag);
            dp_stall = vecs[v].dps != 0;
            ports($sformatf("vec%0d", v), vecs[v].e0v, vecs[v].e0r, vecs[v].e1v, vecs[v].e1r);
            check($sformatf("vec%0d free_cnt", v), int'(free_cnt), vecs[v].ecnt);
            check($sformatf("vec%0d full", v), int'(full), vecs[v].efull);
            tick();
        end

        // Fill slots 0..9, then free slot 0 so its refill is younger than slot 9
        lane(0, 40, 30, 0); lane(1, 41, 33, 0); tick();
        lane(0, 42, 33, 0); lane(1, 43, 33, 0); tick();
        lane(0, 44, 33, 0); lane(1, 45, 33, 0); tick();
        lane(0, 46, 33, 0); lane(1, 47, 33, 0); tick();
        lane(0, 48, 33, 0); lane(1, 49, 34, 0); tick();
        check("fill10 free_cnt", int'(free_cnt), 6);
        ports("fill10", 0, 0, 0, 0);
        bcast(0, 30); tick();
        ports("wake slot0", 1, 40, 0, 0);
        tick();
        check("refill free_cnt", int'(free_cnt), 7);
        lane(0, 50, 34, 0); lane(1, 51, 33, 0); tick();
        check("fill11 free_cnt", int'(free_cnt), 5);
        lane(0, 52, 33, 0); lane(1, 53, 33, 0); tick();
        check("fill13 free_cnt", int'(free_cnt), 3);
        lane(0, 54, 33, 0); tick();
        check("at ways free_cnt", int'(free_cnt), 2);
        check("at ways full", int'(full), 0);
        lane(0, 55, 33, 0); tick();
        check("fill15 free_cnt", int'(free_cnt), 1);
        check("fill15 full", int'(full), 1);
        lane(0, 60, 0, 1); lane(1, 61, 0, 1); tick();
        check("full drop free_cnt", int'(free_cnt), 1);
        ports("full drop", 0, 0, 0, 0);
        bcast(1, 34); tick();
        ports("age order", 1, 49, 1, 50);
        check("age free_cnt", int'(free_cnt), 1);
        bcast(0, 33); tick();

        for (int c = 0; c < 3; c++) begin
            is_stall = 2'b11;
            ports($sformatf("stall%0d", c), 1, 41, 1, 42);
            check($sformatf("stall%0d free_cnt", c), int'(free_cnt), 3);
            tick();
        end
        is_stall = 2'b01;
        ports("stall p0 only", 1, 41, 1, 42);
        tick();
        ports("held p0", 1, 41, 1, 43);
        check("held free_cnt", int'(free_cnt), 4);
        tick();
        ports("released", 1, 44, 1, 45);
        check("pre flush free_cnt", int'(free_cnt), 6);
        flush = 1'b1;
        lane(0, 70, 0, 1);
        tick();
        check("flush free_cnt", int'(free_cnt), 16);
        ports("flush", 0, 0, 0, 0);
        tick();
        ports("flush dropped", 0, 0, 0, 0);
        check("flush dropped free_cnt", int'(free_cnt), 16);

        lane(0, 9, 0, 1); rn[0].fu = FU_LOAD;
        lane(1, 10, 0, 1); rn[1].fu = FU_MULT;
        tick();
        ports("fu decode", 1, 9, 1, 10);
        check("p0 LOAD_ready", int'(pkt[0].LOAD_ready), 1);
        check("p0 ALU_ready", int'(pkt[0].ALU_ready), 0);
        check("p1 MULT_ready", int'(pkt[1].MULT_ready), 1);
        tick();

        lane(0, 80, 0, 1); tick();
        is_stall = 2'b01;
        ports("pre reset", 1, 80, 0, 0);
        check("pre reset free_cnt", int'(free_cnt), 15);
        #2 reset_n = 1'b0;
        #1;
        ports("async reset", 0, 0, 0, 0);
        check("async reset free_cnt", int'(free_cnt), 16);
        check("async reset full", int'(full), 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle();
        #1;
        check("post reset free_cnt", int'(free_cnt), 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
